// File: rtl/bitrev_drain_if.sv
// Reader-side bundle between the bit-reverse FIFO, the drain and its downstream consumer.
// The master modport is the drain itself; the slave modport is the surrounding logic.
interface bitrev_drain_if #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_POINT  = 8192
);
    localparam int PW = $clog2($clog2(MAX_POINT));

    logic [PW-1:0]         point;
    logic                  src_empty;
    logic                  src_pop;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_last;
    logic                  m_ready;
    logic                  frame_done;
    logic                  err;

    modport master (
        input  point, src_empty, src_data, src_valid, m_ready,
        output src_pop, m_data, m_valid, m_last, frame_done, err
    );

    modport slave (
        output point, src_empty, src_data, src_valid, m_ready,
        input  src_pop, m_data, m_valid, m_last, frame_done, err
    );
endinterface

// File: rtl/bitrev_drain.sv
// Pops the bit-reverse FIFO and re-times its fixed-latency returns into a FWFT valid/ready stream with m_last.
// Latency: pop at t -> m_valid at t+LATENCY+1. Pops stop when buffered + in-flight words would exceed DEPTH.
module bitrev_drain #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_POINT  = 8192,
    parameter int LATENCY    = 2,
    parameter int DEPTH      = 4
) (
    input  logic            clk,
    input  logic            rst,
    bitrev_drain_if.master  bus
);
    localparam int PW = $clog2($clog2(MAX_POINT));
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(MAX_POINT);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [LATENCY-1:0] inflight_q, inflight_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [PW-1:0]      point_q, point_d;
    logic               err_q, err_d;
    logic               frame_done_q, frame_done_d;

    logic               pop;
    logic               rd;
    logic               wr;
    logic               full;
    logic               last;
    logic [BW:0]        frame_len;
    logic [BW-1:0]      thre;
    int unsigned        used;

    always_comb begin
        // Credit counts buffered words plus returns still in flight; a same-cycle read is not credited.
        used = 32'(count_q);
        for (int i = 0; i < LATENCY; i++) begin
            used = used + 32'(inflight_q[i]);
        end
        pop = !rst && !bus.src_empty && (used < 32'(DEPTH));

        frame_len = (BW+1)'(1) << point_q;
        thre      = BW'(frame_len - (BW+1)'(1));

        full = (count_q == CW'(DEPTH));
        rd   = (count_q != '0) && bus.m_ready;
        wr   = bus.src_valid && (!full || rd);
        last = (count_q != '0) && (beat_q == thre);

        mem_d = mem_q;
        if (wr) begin
            mem_d[wr_ptr_q] = bus.src_data;
        end
        wr_ptr_d = wr_ptr_q + AW'(wr);
        rd_ptr_d = rd_ptr_q + AW'(rd);

        count_d = count_q;
        if (wr && !rd) begin
            count_d = count_q + CW'(1);
        end else if (rd && !wr) begin
            count_d = count_q - CW'(1);
        end

        inflight_d = (inflight_q << 1) | LATENCY'(pop);

        err_d = err_q || (bus.src_valid && (!inflight_q[LATENCY-1] || !wr));

        beat_d       = beat_q;
        point_d      = point_q;
        frame_done_d = 1'b0;
        if (rd) begin
            if (last) begin
                beat_d       = '0;
                point_d      = bus.point;
                frame_done_d = 1'b1;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= '0;
            beat_q       <= '0;
            point_q      <= bus.point;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            beat_q       <= beat_d;
            point_q      <= point_d;
            err_q        <= err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.src_pop    = pop;
    assign bus.m_valid    = (count_q != '0);
    assign bus.m_data     = mem_q[rd_ptr_q];
    assign bus.m_last     = last;
    assign bus.frame_done = frame_done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_bitrev_drain.sv
// Directed bench: fixed-latency upstream model plus per-scenario tasks with hand-derived expectations.
module tb_bitrev_drain;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bitrev_drain_if bus ();

    bitrev_drain dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic        stage1   = 1'b0;
    logic        pop_seen = 1'b0;
    logic        inject   = 1'b0;
    logic [63:0] next_val = '0;

    // Upstream: returns 0,1,2,... exactly two cycles after each pop; cleared with the drain.
    always begin
        @(negedge clk);
        pop_seen = bus.src_pop;
        @(posedge clk);
        #1;
        if (rst) begin
            stage1        = 1'b0;
            bus.src_valid = 1'b0;
            bus.src_data  = '0;
            next_val      = '0;
        end else begin
            bus.src_valid = stage1 | inject;
            bus.src_data  = stage1 ? next_val : 64'hDEAD;
            if (stage1) next_val = next_val + 64'd1;
            stage1 = pop_seen;
        end
    end

    task automatic do_reset(input logic [3:0] p, input logic ready);
        rst           = 1'b1;
        bus.point     = p;
        bus.src_empty = 1'b0;
        bus.m_ready   = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #2;
        end
        rst         = 1'b0;
        bus.m_ready = ready;
    endtask

    task automatic test_reset;
        rst           = 1'b1;
        bus.point     = 4'd3;
        bus.src_empty = 1'b0;
        bus.m_ready   = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            n_tests++; if (bus.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
            n_tests++; if (bus.m_last !== 1'b0) begin n_fail++; $display("FAIL reset_m_last: got %b want 0", bus.m_last); end
            n_tests++; if (bus.m_data !== 64'd0) begin n_fail++; $display("FAIL reset_m_data: got %h want 0", bus.m_data); end
            n_tests++; if (bus.src_pop !== 1'b0) begin n_fail++; $display("FAIL reset_src_pop: got %b want 0", bus.src_pop); end
            n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
            n_tests++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
        end
    endtask

    task automatic test_stream;
        int words = 0;
        int first_pop = -1;
        int first_vld = -1;
        int fd = 0;
        int done_at = -1;
        do_reset(4'd3, 1'b1);
        for (int cyc = 0; cyc < 40 && (done_at < 0 || cyc <= done_at + 2); cyc++) begin
            @(negedge clk);
            n_tests++; if (bus.src_pop !== 1'b1) begin n_fail++; $display("FAIL stream_pop cyc %0d: got %b want 1", cyc, bus.src_pop); end
            if (first_pop < 0 && bus.src_pop) first_pop = cyc;
            if (first_vld < 0 && bus.m_valid) first_vld = cyc;
            if (bus.frame_done) fd++;
            if (bus.m_valid && bus.m_ready && words < 8) begin
                n_tests++; if (bus.m_data !== 64'(words)) begin n_fail++; $display("FAIL stream_data: got %0d want %0d", bus.m_data, words); end
                n_tests++; if (bus.m_last !== (words == 7)) begin n_fail++; $display("FAIL stream_last word %0d: got %b want %b", words, bus.m_last, words == 7); end
                words++;
                if (words == 8) done_at = cyc;
            end
        end
        n_tests++; if (words != 8) begin n_fail++; $display("FAIL stream_words: got %0d want 8", words); end
        n_tests++; if (first_pop != 0) begin n_fail++; $display("FAIL stream_first_pop: got %0d want 0", first_pop); end
        n_tests++; if (first_vld != 3) begin n_fail++; $display("FAIL stream_first_valid: got %0d want 3", first_vld); end
        n_tests++; if (fd != 1) begin n_fail++; $display("FAIL stream_frame_done: got %0d pulses want 1", fd); end
    endtask

    task automatic test_backpressure;
        int pops = 0;
        int pops_after = 0;
        int words = 0;
        do_reset(4'd3, 1'b0);
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (bus.src_pop) pops++;
        end
        n_tests++; if (pops != 4) begin n_fail++; $display("FAIL bp_pops: got %0d want 4", pops); end
        n_tests++; if (bus.src_pop !== 1'b0) begin n_fail++; $display("FAIL bp_pop_stalled: got %b want 0", bus.src_pop); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL bp_err: got %b want 0", bus.err); end
        n_tests++; if (bus.m_valid !== 1'b1 || bus.m_data !== 64'd0) begin n_fail++; $display("FAIL bp_head: got valid %b data %0d want 1/0", bus.m_valid, bus.m_data); end
        @(posedge clk);
        #2;
        bus.m_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && words < 8; cyc++) begin
            @(negedge clk);
            if (bus.src_pop) pops_after++;
            if (bus.m_valid && bus.m_ready) begin
                n_tests++; if (bus.m_data !== 64'(words)) begin n_fail++; $display("FAIL bp_data: got %0d want %0d", bus.m_data, words); end
                words++;
            end
        end
        n_tests++; if (words != 8) begin n_fail++; $display("FAIL bp_drain_words: got %0d want 8", words); end
        n_tests++; if (pops_after < 4) begin n_fail++; $display("FAIL bp_resume: got %0d pops want >=4", pops_after); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL bp_err_end: got %b want 0", bus.err); end
    endtask

    task automatic test_empty_gating;
        int pops = 0;
        int words = 0;
        do_reset(4'd3, 1'b1);
        for (int cyc = 0; cyc < 50; cyc++) begin
            bus.src_empty = (cyc < 30) ? cyc[0] : 1'b1;
            @(negedge clk);
            n_tests++; if (bus.src_empty && bus.src_pop) begin n_fail++; $display("FAIL gate_pop_when_empty cyc %0d: got 1 want 0", cyc); end
            if (bus.src_pop) pops++;
            if (bus.m_valid && bus.m_ready) begin
                n_tests++; if (bus.m_data !== 64'(words)) begin n_fail++; $display("FAIL gate_data: got %0d want %0d", bus.m_data, words); end
                words++;
            end
            @(posedge clk);
            #2;
        end
        n_tests++; if (words != pops || pops != 15) begin n_fail++; $display("FAIL gate_count: got %0d words %0d pops want 15/15", words, pops); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL gate_err: got %b want 0", bus.err); end
    endtask

    task automatic test_err;
        do_reset(4'd3, 1'b1);
        bus.src_empty = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_initial: got %b want 0", bus.err); end
        @(posedge clk);
        #2;
        inject = 1'b1;
        @(posedge clk);
        #2;
        inject = 1'b0;
        @(negedge clk);
        n_tests++; if (bus.src_valid !== 1'b1 || bus.err !== 1'b0) begin n_fail++; $display("FAIL err_inject_cycle: got valid %b err %b want 1/0", bus.src_valid, bus.err); end
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            n_tests++; if (bus.err !== 1'b1) begin n_fail++; $display("FAIL err_sticky cyc %0d: got %b want 1", cyc, bus.err); end
        end
        do_reset(4'd3, 1'b1);
        @(negedge clk);
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", bus.err); end
    endtask

    task automatic test_point_latch;
        int words = 0;
        int fd = 0;
        do_reset(4'd2, 1'b1);
        for (int cyc = 0; cyc < 60 && words < 14; cyc++) begin
            @(negedge clk);
            if (bus.frame_done) fd++;
            if (bus.m_valid && bus.m_ready) begin
                n_tests++; if (bus.m_data !== 64'(words)) begin n_fail++; $display("FAIL latch_data: got %0d want %0d", bus.m_data, words); end
                n_tests++; if (bus.m_last !== (words == 3 || words == 11)) begin n_fail++; $display("FAIL latch_last word %0d: got %b want %b", words, bus.m_last, (words == 3 || words == 11)); end
                if (words == 1) bus.point = 4'd3;
                words++;
            end
        end
        n_tests++; if (words != 14) begin n_fail++; $display("FAIL latch_words: got %0d want 14", words); end
        n_tests++; if (fd != 2) begin n_fail++; $display("FAIL latch_frame_done: got %0d pulses want 2", fd); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.point     = 4'd3;
        bus.src_empty = 1'b0;
        bus.m_ready   = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_empty_gating();
        test_err();
        test_point_latch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
